// File: rtl/fetch_sequencer.sv
// Fetch sequencer: arbitrates branch/jump redirects, load-use stalls and halt
// for the fetch stage, and counts stall cycles.
module fetch_sequencer #(
  parameter logic [4:0] OP_JMP  = 5'b11000,
  parameter logic [4:0] OP_LOAD = 5'b10100,
  parameter logic [4:0] OP_HLT  = 5'b11111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [23:0] id_ins,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  input  logic       ex_br_taken,
  input  logic [7:0] ex_br_target,
  input  logic       resume,
  output logic       Stall,
  output logic       Stall_pm,
  output logic       pc_mux_sel,
  output logic [7:0] jmp_loc,
  output logic       flush,
  output logic       halted,
  output logic [7:0] stall_count
);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_HALT} state_t;

  state_t     state_q, state_d;
  logic       skip_hlt_q, skip_hlt_d;
  logic       halted_q, halted_d;
  logic [7:0] cnt_q, cnt_d;

  logic       stall_raw, stall_pm_raw, pc_sel_raw, flush_raw;
  logic [7:0] jmp_raw;

  logic [4:0] opcode, rs1, rs2;
  logic       load_use;
  logic       unused_fields;

  assign opcode   = id_ins[23:19];
  assign rs1      = id_ins[13:9];
  assign rs2      = id_ins[8:4];
  assign load_use = ex_is_load && (ex_rd != '0) && ((ex_rd == rs1) || (ex_rd == rs2));

  // rd field and the load opcode are not needed for sequencing decisions
  assign unused_fields = ^{id_ins[18:14], OP_LOAD};

  always_comb begin
    state_d      = state_q;
    skip_hlt_d   = 1'b0;
    stall_raw    = 1'b0;
    stall_pm_raw = 1'b0;
    pc_sel_raw   = 1'b0;
    flush_raw    = 1'b0;
    jmp_raw      = '0;

    case (state_q)
      S_RUN: begin
        if (ex_br_taken) begin
          pc_sel_raw = 1'b1;
          jmp_raw    = ex_br_target;
          flush_raw  = 1'b1;
          state_d    = S_FLUSH;
        end else if (opcode == OP_JMP) begin
          pc_sel_raw = 1'b1;
          jmp_raw    = id_ins[7:0];
          state_d    = S_FLUSH;
        end else if (load_use) begin
          stall_raw    = 1'b1;
          stall_pm_raw = 1'b1;
          flush_raw    = 1'b1;
          state_d      = S_STALL;
        end else if ((opcode == OP_HLT) && !skip_hlt_q) begin
          stall_raw    = 1'b1;
          stall_pm_raw = 1'b1;
          flush_raw    = 1'b1;
          state_d      = S_HALT;
        end
      end
      S_FLUSH: begin
        flush_raw = 1'b1;
        state_d   = S_RUN;
        if (ex_br_taken) begin
          pc_sel_raw = 1'b1;
          jmp_raw    = ex_br_target;
          state_d    = S_FLUSH;
        end
      end
      S_STALL: state_d = S_RUN;
      S_HALT: begin
        // The HLT is still in ID on the resume cycle, so the first RUN cycle skips it
        stall_raw    = !resume;
        stall_pm_raw = 1'b1;
        flush_raw    = 1'b1;
        if (resume) begin
          state_d    = S_RUN;
          skip_hlt_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase

    halted_d = (state_d == S_HALT);
    cnt_d    = (stall_raw && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RUN;
      skip_hlt_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      skip_hlt_q <= skip_hlt_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Stall       = reset & stall_raw;
  assign Stall_pm    = reset & stall_pm_raw;
  assign pc_mux_sel  = reset & pc_sel_raw;
  assign flush       = reset & flush_raw;
  assign jmp_loc     = (reset && pc_sel_raw) ? jmp_raw : '0;
  assign halted      = halted_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic against a rule-level reference model.
module tb_fetch_sequencer;

  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_LOAD = 5'b10100;
  localparam logic [4:0] OP_HLT  = 5'b11111;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] id_ins;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_br_taken;
  logic [7:0]  ex_br_target;
  logic        resume;
  logic        Stall, Stall_pm, pc_mux_sel, flush, halted;
  logic [7:0]  jmp_loc, stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model: booleans describing what the pipeline is doing
  bit       m_halted, m_redirect, m_bubble, m_skip;
  int       m_count;
  bit       e_stall, e_pm, e_pc, e_fl;
  logic [7:0] e_jl;
  bit       n_halted, n_redirect, n_bubble, n_skip;

  fetch_sequencer #(.OP_JMP(OP_JMP), .OP_LOAD(OP_LOAD), .OP_HLT(OP_HLT)) dut (
    .clk(clk), .reset(reset), .id_ins(id_ins), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .resume(resume), .Stall(Stall), .Stall_pm(Stall_pm), .pc_mux_sel(pc_mux_sel),
    .jmp_loc(jmp_loc), .flush(flush), .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [4:0] op, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [7:0] tgt);
    logic [23:0] w;
    w = {op, 5'd0, rs1, rs2, 4'd0};
    w[7:0] = w[7:0] | tgt;
    return w;
  endfunction

  task automatic idle_inputs();
    id_ins = '0; ex_is_load = 0; ex_rd = '0; ex_br_taken = 0;
    ex_br_target = '0; resume = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 0;
    m_halted = 0; m_redirect = 0; m_bubble = 0; m_skip = 0; m_count = 0;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic model_eval();
    bit lu, hit_hlt;
    e_stall = 0; e_pm = 0; e_pc = 0; e_fl = 0; e_jl = 8'h00;
    n_halted = 0; n_redirect = 0; n_bubble = 0; n_skip = 0;
    lu = ex_is_load && ex_rd != 0 && (ex_rd == id_ins[13:9] || ex_rd == id_ins[8:4]);
    hit_hlt = (id_ins[23:19] == OP_HLT) && !m_skip;
    if (m_halted) begin
      e_pm = 1; e_fl = 1; e_stall = !resume;
      n_halted = !resume; n_skip = resume;
    end else if (m_bubble) begin
      // load-use bubble cycle: nothing happens
    end else if (ex_br_taken) begin
      e_pc = 1; e_jl = ex_br_target; e_fl = 1; n_redirect = 1;
    end else if (m_redirect) begin
      e_fl = 1;
    end else if (id_ins[23:19] == OP_JMP) begin
      e_pc = 1; e_jl = id_ins[7:0]; n_redirect = 1;
    end else if (lu) begin
      e_stall = 1; e_pm = 1; e_fl = 1; n_bubble = 1;
    end else if (hit_hlt) begin
      e_stall = 1; e_pm = 1; e_fl = 1; n_halted = 1;
    end
  endtask

  task automatic model_step();
    if (e_stall && m_count < 255) m_count++;
    m_halted = n_halted; m_redirect = n_redirect; m_bubble = n_bubble; m_skip = n_skip;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    ex_br_taken = 1; ex_br_target = 8'h5A; id_ins = mk(OP_HLT, 0, 0, 0);
    #12;
    checks++;
    if ({Stall, Stall_pm, pc_mux_sel, flush, halted} !== 5'b0 || jmp_loc !== 8'h00 || stall_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got S=%b Spm=%b pc=%b fl=%b h=%b jl=%h cnt=%h, want all 0",
               Stall, Stall_pm, pc_mux_sel, flush, halted, jmp_loc, stall_count);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    ex_is_load = 1; ex_rd = 5; id_ins = mk(5'b00001, 5, 9, 8'h00);
    #1 checks++;
    if ({Stall, Stall_pm, pc_mux_sel, flush} !== 4'b1101) begin
      errors++;
      $display("FAIL load_use_stall: got S=%b Spm=%b pc=%b fl=%b, want 1 1 0 1", Stall, Stall_pm, pc_mux_sel, flush);
    end
    @(negedge clk);  // same inputs held: must not re-detect in the bubble cycle
    #1 checks++;
    if ({Stall, Stall_pm, pc_mux_sel, flush} !== 4'b0000 || stall_count !== 8'd1) begin
      errors++;
      $display("FAIL load_use_bubble: got S=%b Spm=%b pc=%b fl=%b cnt=%0d, want 0 0 0 0 cnt=1",
               Stall, Stall_pm, pc_mux_sel, flush, stall_count);
    end
    do_reset();
  endtask

  task automatic test_ex_rd_zero();
    @(negedge clk);
    ex_is_load = 1; ex_rd = 0; id_ins = mk(5'b00001, 0, 0, 8'h00);
    #1 checks++;
    if (Stall !== 1'b0 || flush !== 1'b0) begin
      errors++;
      $display("FAIL rd_zero_no_stall: got S=%b fl=%b, want 0 0", Stall, flush);
    end
    do_reset();
  endtask

  task automatic test_branch_vs_jump();
    @(negedge clk);
    ex_br_taken = 1; ex_br_target = 8'h40; id_ins = {OP_JMP, 11'd0, 8'h10};
    #1 checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h40 || flush !== 1'b1 || Stall !== 1'b0) begin
      errors++;
      $display("FAIL branch_priority: got pc=%b jl=%h fl=%b S=%b, want 1 40 1 0", pc_mux_sel, jmp_loc, flush, Stall);
    end
    @(negedge clk);
    idle_inputs();
    #1 checks++;
    if ({pc_mux_sel, flush, Stall, Stall_pm} !== 4'b0100 || jmp_loc !== 8'h00) begin
      errors++;
      $display("FAIL branch_flush_cycle: got pc=%b fl=%b S=%b Spm=%b jl=%h, want 0 1 0 0 00",
               pc_mux_sel, flush, Stall, Stall_pm, jmp_loc);
    end
    @(negedge clk);
    #1 checks++;
    if ({pc_mux_sel, flush} !== 2'b00) begin
      errors++;
      $display("FAIL branch_back_to_run: got pc=%b fl=%b, want 0 0", pc_mux_sel, flush);
    end
    do_reset();
  endtask

  task automatic test_jump();
    @(negedge clk);
    id_ins = {OP_JMP, 11'd0, 8'h22};
    #1 checks++;
    if (pc_mux_sel !== 1'b1 || jmp_loc !== 8'h22 || flush !== 1'b0) begin
      errors++;
      $display("FAIL jump_redirect: got pc=%b jl=%h fl=%b, want 1 22 0", pc_mux_sel, jmp_loc, flush);
    end
    @(negedge clk);
    id_ins = {OP_JMP, 11'd0, 8'h33};  // ignored during the flush cycle
    #1 checks++;
    if (pc_mux_sel !== 1'b0 || jmp_loc !== 8'h00 || flush !== 1'b1) begin
      errors++;
      $display("FAIL jump_flush: got pc=%b jl=%h fl=%b, want 0 00 1", pc_mux_sel, jmp_loc, flush);
    end
    do_reset();
  endtask

  task automatic test_halt_resume();
    int bad;
    @(negedge clk);
    id_ins = mk(OP_HLT, 0, 0, 8'h00);
    #1 checks++;
    if ({Stall, Stall_pm, flush, halted} !== 4'b1110) begin
      errors++;
      $display("FAIL halt_decode: got S=%b Spm=%b fl=%b h=%b, want 1 1 1 0", Stall, Stall_pm, flush, halted);
    end
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1 if ({Stall, Stall_pm, flush, halted} !== 4'b1111) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d of 300 cycles not S=Spm=fl=h=1", bad);
    end
    checks++;
    if (stall_count !== 8'hFF) begin
      errors++;
      $display("FAIL stall_count_sat: got %h, want ff", stall_count);
    end
    @(negedge clk);
    resume = 1;
    #1 checks++;
    if ({Stall, Stall_pm, flush} !== 3'b011) begin
      errors++;
      $display("FAIL resume_cycle: got S=%b Spm=%b fl=%b, want 0 1 1", Stall, Stall_pm, flush);
    end
    @(negedge clk);
    resume = 0;  // HLT still in ID: must be skipped once
    #1 checks++;
    if ({Stall, halted, flush} !== 3'b000 || stall_count !== 8'hFF) begin
      errors++;
      $display("FAIL resume_run: got S=%b h=%b fl=%b cnt=%h, want 0 0 0 ff", Stall, halted, flush, stall_count);
    end
    @(negedge clk);
    #1 checks++;
    if (Stall !== 1'b1) begin
      errors++;
      $display("FAIL hlt_skip_once: got S=%b, want 1 on second RUN cycle", Stall);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    id_ins = mk(OP_HLT, 0, 0, 8'h00);
    repeat (3) @(negedge clk);
    #2 reset = 0;
    #1 checks++;
    if (halted !== 1'b0 || Stall !== 1'b0 || stall_count !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_halt: got h=%b S=%b cnt=%h, want 0 0 00", halted, Stall, stall_count);
    end
    @(negedge clk);
    idle_inputs();
    reset = 1;
    #1 checks++;
    if ({Stall, Stall_pm, flush, pc_mux_sel, halted} !== 5'b0) begin
      errors++;
      $display("FAIL run_after_halt_reset: got S=%b Spm=%b fl=%b pc=%b h=%b, want all 0",
               Stall, Stall_pm, flush, pc_mux_sel, halted);
    end
    @(negedge clk);
    id_ins = {OP_JMP, 11'd0, 8'h77};
    @(negedge clk);
    id_ins = '0;
    #1 reset = 0;
    @(negedge clk);
    reset = 1;
    #1 checks++;
    if (flush !== 1'b0 || pc_mux_sel !== 1'b0) begin
      errors++;
      $display("FAIL run_after_flush_reset: got fl=%b pc=%b, want 0 0", flush, pc_mux_sel);
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad, first_bad;
    logic [4:0] op;
    bad = 0; first_bad = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      case ($urandom_range(0, 9))
        0, 1:    op = OP_JMP;
        2:       op = OP_HLT;
        3:       op = OP_LOAD;
        default: op = 5'($urandom_range(0, 31));
      endcase
      id_ins       = {op, 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 4'($urandom)};
      ex_is_load   = 1'($urandom_range(0, 1));
      ex_rd        = 5'($urandom_range(0, 7));
      ex_br_taken  = ($urandom_range(0, 5) == 0);
      ex_br_target = 8'($urandom);
      resume       = ($urandom_range(0, 3) == 0);
      #1 model_eval();
      checks++;
      if ({Stall, Stall_pm, pc_mux_sel, flush, halted} !== {e_stall, e_pm, e_pc, e_fl, m_halted} ||
          jmp_loc !== e_jl || stall_count !== 8'(m_count)) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cycle_%0d: got S=%b Spm=%b pc=%b fl=%b h=%b jl=%h cnt=%h, want %b %b %b %b %b %h %h",
                   i, Stall, Stall_pm, pc_mux_sel, flush, halted, jmp_loc, stall_count,
                   e_stall, e_pm, e_pc, e_fl, m_halted, e_jl, 8'(m_count));
      end
      model_step();
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_ex_rd_zero();
    test_branch_vs_jump();
    test_jump();
    test_halt_resume();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
